memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Receiving end of the EX->MEM pipeline interface. Accepts execute results, performs loads and stores over a valid/ready data-memory port, and forwards results to writeback.
- Drives MEMEX_stall back to execute while an access is outstanding.
- Drives the MEMEX_rd/MEMEX_rdval forwarding pair consumed by execute.

Parameters:
- XLEN, 64, datapath and address width.
- REG_W, 6, destination register index width.
- RESP_TIMEOUT, 255, maximum cycles in WAIT before the access is aborted as a bus error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; low = in reset.
- EXMEM_ready  in  1  EX output valid this cycle.
- exmm_aluresult  in  XLEN  ALU result, or effective address when mem_active=1.
- EXMEM_rs2  in  XLEN  store data.
- dest_reg  in  REG_W  destination register; 0 = no write.
- mem_active  in  1  instruction accesses memory.
- load  in  1  1 = load, 0 = store (only meaningful when mem_active=1).
- EXMEM_size  in  2  access size: 0=byte, 1=half, 2=word, 3=double.
- EXMEM_unsigned  in  1  zero-extend load data (lbu/lhu/lwu).
- MEMEX_stall  out  1  EX must hold its outputs.
- MEMEX_rd  out  REG_W  forwarding destination register.
- MEMEX_rdval  out  XLEN  forwarding value.
- MEMWB_ready  out  1  writeback entry valid (one-cycle pulse).
- MEMWB_rd  out  REG_W  writeback destination register.
- MEMWB_val  out  XLEN  writeback value.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_addr  out  XLEN  address, 8-byte aligned (addr[2:0] forced to 0).
- dmem_we  out  1  1 = write.
- dmem_wstrb  out  8  byte-lane enables.
- dmem_wdata  out  XLEN  store data replicated into the addressed lanes.
- dmem_resp_valid  in  1  response/ack valid.
- dmem_rdata  in  XLEN  read data.
- mem_err  out  1  one-cycle pulse on misaligned access or timeout.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE and the timeout counter clears.
  - All outputs are 0, including dmem_req_valid. A request in flight is dropped.
  - A response arriving after reset release while in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- MEMEX_stall = (state != IDLE), purely combinational from state. Inputs are sampled only in IDLE.
- IDLE with EXMEM_ready=1 and mem_active=0:
  - Next cycle: MEMWB_ready=1, MEMWB_rd=dest_reg, MEMWB_val=exmm_aluresult.
  - Latency is 1 cycle and there is no stall.
- IDLE with EXMEM_ready=1 and mem_active=1:
  - Alignment check: half requires addr[0]=0; word requires addr[1:0]=0; double requires addr[2:0]=0.
  - Misaligned: next cycle mem_err=1, MEMWB_ready=1, MEMWB_rd=0, MEMWB_val=0. No request is issued and state stays IDLE.
  - Aligned: latch address, lane offset addr[2:0], size, unsigned flag, load flag, rd and store data, then go to REQ.
  - Stores latch rd as 0.
- REQ:
  - dmem_req_valid=1 and the request fields are held stable until dmem_req_ready=1.
  - On req_ready, go to WAIT and clear the counter.
  - A dmem_resp_valid seen in REQ is ignored.
- Store lane rules:
  - wstrb is the size mask (0x01, 0x03, 0x0F, 0xFF) shifted left by the lane offset.
  - wdata is the low 8/16/32/64 bits of rs2 shifted left by 8*offset.
- WAIT with dmem_resp_valid=1:
  - Load data = dmem_rdata >> (8*offset), truncated to the access size, then sign-extended (or zero-extended if EXMEM_unsigned).
  - Next cycle: MEMWB_ready=1 with the latched rd and the extended value; a store's ack gives rd=0, val=0. State returns to IDLE.
- WAIT without a response:
  - The counter increments each cycle.
  - When counter == RESP_TIMEOUT-1 and no response has arrived: mem_err pulses, MEMWB_ready=1 with rd=0, val=0, and state returns to IDLE.
  - A response on the same edge as the timeout is taken as a valid completion.
- Back-to-back handoff:
  - The cycle stall falls, EX presents its held instruction and MEM samples it.
  - A new access therefore starts no sooner than the cycle after MEMWB_ready.
- Forwarding:
  - MEMEX_rd = MEMWB_ready ? MEMWB_rd : 0.
  - MEMEX_rdval = MEMWB_ready ? MEMWB_val : 0.
- MEMWB_ready is a one-cycle pulse; MEMWB_rd and MEMWB_val hold their last value otherwise.

Test Plan:
- ALU passthrough: exmm_aluresult=0x1234, dest_reg=5, mem_active=0 -> next cycle MEMWB_ready=1, rd=5, val=0x1234, MEMEX_rd=5, stall never asserted.
- Signed byte load: addr=0x1003, size=0, unsigned=0, rdata=0x00000000_80000000, req_ready after 2 cycles, resp 3 cycles later.
  - Required: dmem_addr=0x1000, stall high throughout; val=0xFFFFFFFF_FFFFFF80. Repeating with unsigned=1 gives 0x80.
- Word store: addr=0x2004, size=2, rs2=0xAABBCCDD_11223344, ack after 1 cycle -> wstrb=0xF0, wdata upper half=0x11223344, we=1, MEMWB_rd=0.
- Misaligned half load: addr=0x3001 -> no dmem_req_valid, mem_err pulse, MEMWB_rd=0.
- Timeout: RESP_TIMEOUT=4, request accepted, no response -> mem_err and return to IDLE exactly 4 cycles after entering WAIT.
  - A response arriving later in IDLE is ignored.
- Reset mid-access: reset low while in WAIT -> immediately all outputs 0 and state IDLE; after release, a passthrough op completes normally in 1 cycle.

Source files
------------

// File: rtl/memory_stage_if.sv
// Data-memory port between the memory stage (master) and the data memory (slave).
interface memory_stage_if #(parameter int XLEN = 64);
  // A request transfers on a rising edge where dmem_req_valid && dmem_req_ready;
  // the master holds all request fields stable while valid is high and ready low.
  // The slave answers each accepted request with exactly one dmem_resp_valid pulse.
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_we;
  logic [7:0]      dmem_wstrb;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: passes ALU results through, performs aligned loads/stores
// over the data-memory port, and stalls execute while an access is outstanding.
module memory_stage #(
  parameter int XLEN         = 64,
  parameter int REG_W        = 6,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EXMEM_ready,
  input  logic [XLEN-1:0]  exmm_aluresult,
  input  logic [XLEN-1:0]  EXMEM_rs2,
  input  logic [REG_W-1:0] dest_reg,
  input  logic             mem_active,
  input  logic             load,
  input  logic [1:0]       EXMEM_size,
  input  logic             EXMEM_unsigned,
  output logic             MEMEX_stall,
  output logic [REG_W-1:0] MEMEX_rd,
  output logic [XLEN-1:0]  MEMEX_rdval,
  output logic             MEMWB_ready,
  output logic [REG_W-1:0] MEMWB_rd,
  output logic [XLEN-1:0]  MEMWB_val,
  output logic             mem_err,
  output logic [1:0]       dbg_state,
  memory_stage_if.master   dmem
);

  localparam int CNT_W = $clog2(RESP_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t           state;
  logic [2:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             load_q;
  logic [REG_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt;

  logic             misaligned;
  logic [7:0]       size_mask;
  logic [XLEN-1:0]  store_data;
  logic [XLEN-1:0]  rdata_shifted;
  logic [XLEN-1:0]  load_val;

  assign MEMEX_stall = (state != IDLE);
  assign MEMEX_rd    = MEMWB_ready ? MEMWB_rd  : '0;
  assign MEMEX_rdval = MEMWB_ready ? MEMWB_val : '0;
  assign dbg_state   = state;

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h00;
    store_data = '0;
    case (EXMEM_size)
      2'd0: begin
        size_mask  = 8'h01;
        store_data = {{(XLEN-8){1'b0}}, EXMEM_rs2[7:0]};
      end
      2'd1: begin
        misaligned = exmm_aluresult[0];
        size_mask  = 8'h03;
        store_data = {{(XLEN-16){1'b0}}, EXMEM_rs2[15:0]};
      end
      2'd2: begin
        misaligned = |exmm_aluresult[1:0];
        size_mask  = 8'h0F;
        store_data = {{(XLEN-32){1'b0}}, EXMEM_rs2[31:0]};
      end
      default: begin
        misaligned = |exmm_aluresult[2:0];
        size_mask  = 8'hFF;
        store_data = EXMEM_rs2;
      end
    endcase
  end

  // Load data is taken from the addressed lane, then sized and extended.
  always_comb begin
    rdata_shifted = dmem.dmem_rdata >> {off_q, 3'b000};
    load_val      = rdata_shifted;
    case (size_q)
      2'd0: load_val = {{(XLEN-8){~uns_q & rdata_shifted[7]}},   rdata_shifted[7:0]};
      2'd1: load_val = {{(XLEN-16){~uns_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
      2'd2: load_val = {{(XLEN-32){~uns_q & rdata_shifted[31]}}, rdata_shifted[31:0]};
      default: load_val = rdata_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      off_q               <= '0;
      size_q              <= '0;
      uns_q               <= 1'b0;
      load_q              <= 1'b0;
      rd_q                <= '0;
      cnt                 <= '0;
      MEMWB_ready         <= 1'b0;
      MEMWB_rd            <= '0;
      MEMWB_val           <= '0;
      mem_err             <= 1'b0;
      dmem.dmem_req_valid <= 1'b0;
      dmem.dmem_addr      <= '0;
      dmem.dmem_we        <= 1'b0;
      dmem.dmem_wstrb     <= '0;
      dmem.dmem_wdata     <= '0;
    end else begin
      MEMWB_ready <= 1'b0;
      mem_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (EXMEM_ready) begin
            if (!mem_active) begin
              MEMWB_ready <= 1'b1;
              MEMWB_rd    <= dest_reg;
              MEMWB_val   <= exmm_aluresult;
            end else if (misaligned) begin
              mem_err     <= 1'b1;
              MEMWB_ready <= 1'b1;
              MEMWB_rd    <= '0;
              MEMWB_val   <= '0;
            end else begin
              off_q               <= exmm_aluresult[2:0];
              size_q              <= EXMEM_size;
              uns_q               <= EXMEM_unsigned;
              load_q              <= load;
              rd_q                <= load ? dest_reg : '0;
              dmem.dmem_req_valid <= 1'b1;
              dmem.dmem_addr      <= {exmm_aluresult[XLEN-1:3], 3'b000};
              dmem.dmem_we        <= ~load;
              dmem.dmem_wstrb     <= load ? 8'h00 : (size_mask << exmm_aluresult[2:0]);
              dmem.dmem_wdata     <= load ? '0 : (store_data << {exmm_aluresult[2:0], 3'b000});
              state               <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem.dmem_req_ready) begin
            dmem.dmem_req_valid <= 1'b0;
            cnt                 <= '0;
            state               <= WAIT;
          end
        end
        WAIT: begin
          // A response on the timeout edge still counts as a completion.
          if (dmem.dmem_resp_valid) begin
            MEMWB_ready <= 1'b1;
            MEMWB_rd    <= rd_q;
            MEMWB_val   <= load_q ? load_val : '0;
            state       <= IDLE;
          end else if (cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
            mem_err     <= 1'b1;
            MEMWB_ready <= 1'b1;
            MEMWB_rd    <= '0;
            MEMWB_val   <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: driver tasks, a spec-level writeback model
// with an expected queue checked every cycle, and literal spot checks.
module tb_memory_stage;
  localparam int XLEN = 64;
  localparam int REG_W = 6;
  localparam int TO = 4;

  logic             clk;
  logic             reset;
  logic             EXMEM_ready;
  logic [XLEN-1:0]  exmm_aluresult;
  logic [XLEN-1:0]  EXMEM_rs2;
  logic [REG_W-1:0] dest_reg;
  logic             mem_active;
  logic             load;
  logic [1:0]       EXMEM_size;
  logic             EXMEM_unsigned;
  logic             MEMEX_stall;
  logic [REG_W-1:0] MEMEX_rd;
  logic [XLEN-1:0]  MEMEX_rdval;
  logic             MEMWB_ready;
  logic [REG_W-1:0] MEMWB_rd;
  logic [XLEN-1:0]  MEMWB_val;
  logic             mem_err;
  logic [1:0]       dbg_state;

  memory_stage_if #(.XLEN(XLEN)) mif ();

  memory_stage #(.XLEN(XLEN), .REG_W(REG_W), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .EXMEM_ready(EXMEM_ready),
    .exmm_aluresult(exmm_aluresult), .EXMEM_rs2(EXMEM_rs2), .dest_reg(dest_reg),
    .mem_active(mem_active), .load(load), .EXMEM_size(EXMEM_size),
    .EXMEM_unsigned(EXMEM_unsigned), .MEMEX_stall(MEMEX_stall),
    .MEMEX_rd(MEMEX_rd), .MEMEX_rdval(MEMEX_rdval), .MEMWB_ready(MEMWB_ready),
    .MEMWB_rd(MEMWB_rd), .MEMWB_val(MEMWB_val), .mem_err(mem_err),
    .dbg_state(dbg_state), .dmem(mif.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // {err, rd, val}
  logic [1+REG_W+XLEN-1:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // spec-level model
  function automatic logic [63:0] lane_mask(input int nb);
    return (nb >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
  endfunction

  function automatic bit model_misaligned(input logic [63:0] a, input logic [1:0] sz);
    return (a % (64'd1 << sz)) != 0;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] a,
                                             input logic [1:0] sz, input logic uns);
    int nb = 1 << sz;
    logic [63:0] m = lane_mask(nb);
    logic [63:0] v = rdata >> (8 * int'(a % 8));
    v = v & m;
    if (nb < 8 && !uns && v[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [7:0] model_wstrb(input logic [63:0] a, input logic [1:0] sz);
    int nb = 1 << sz;
    int s = ((1 << nb) - 1) << int'(a % 8);
    return s[7:0];
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] rs2, input logic [63:0] a,
                                              input logic [1:0] sz);
    return (rs2 & lane_mask(1 << sz)) << (8 * int'(a % 8));
  endfunction

  // compare process: every writeback pulse must match the model, forwarding idles at 0
  always @(negedge clk) begin
    logic [1+REG_W+XLEN-1:0] e;
    if (reset) begin
      if (MEMWB_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got rd=%0d val=%0h required no writeback", MEMWB_rd, MEMWB_val);
        end else begin
          e = exp_q.pop_front();
          chk("wb_rd", MEMWB_rd, e[XLEN +: REG_W]);
          chk("wb_val", MEMWB_val, e[XLEN-1:0]);
          chk("wb_err", mem_err, e[XLEN+REG_W]);
          chk("fwd_rd", MEMEX_rd, e[XLEN +: REG_W]);
          chk("fwd_val", MEMEX_rdval, e[XLEN-1:0]);
        end
      end else begin
        chk("fwd_idle", {MEMEX_rd, MEMEX_rdval, mem_err}, '0);
      end
    end
  end

  // driver tasks
  task automatic drive_op(input logic [REG_W-1:0] rd, input logic [63:0] a, input logic [63:0] rs2,
                          input logic mem, input logic ld, input logic [1:0] sz, input logic uns);
    @(posedge clk); #1;
    dest_reg = rd; exmm_aluresult = a; EXMEM_rs2 = rs2; mem_active = mem;
    load = ld; EXMEM_size = sz; EXMEM_unsigned = uns; EXMEM_ready = 1'b1;
  endtask

  task automatic run_op(input logic [REG_W-1:0] rd, input logic [63:0] a, input logic [63:0] rs2,
                        input logic mem, input logic ld, input logic [1:0] sz, input logic uns,
                        input int req_dly, input int resp_dly, input logic [63:0] rdata,
                        input bit no_resp);
    bit mis = mem && model_misaligned(a, sz);
    drive_op(rd, a, rs2, mem, ld, sz, uns);
    if (!mem) exp_q.push_back({1'b0, rd, a});
    else if (mis) exp_q.push_back({1'b1, {REG_W{1'b0}}, 64'd0});
    @(posedge clk); #1;
    EXMEM_ready = 1'b0; mem_active = 1'b0;
    if (!mem || mis) begin
      chk("direct_wb", MEMWB_ready, 1'b1);
      chk("direct_no_stall", MEMEX_stall, 1'b0);
      chk("direct_no_req", mif.dmem_req_valid, 1'b0);
      return;
    end
    chk("req_valid", mif.dmem_req_valid, 1'b1);
    chk("req_addr", mif.dmem_addr, a & ~64'd7);
    chk("req_we", mif.dmem_we, !ld);
    if (!ld) begin
      chk("req_wstrb", mif.dmem_wstrb, model_wstrb(a, sz));
      chk("req_wdata", mif.dmem_wdata, model_wdata(rs2, a, sz));
    end
    chk("stall_req", MEMEX_stall, 1'b1);
    repeat (req_dly) begin
      @(posedge clk); #1;
      chk("req_held", {mif.dmem_req_valid, mif.dmem_addr}, {1'b1, a & ~64'd7});
      chk("stall_held", MEMEX_stall, 1'b1);
    end
    mif.dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    mif.dmem_req_ready = 1'b0;
    chk("req_dropped", mif.dmem_req_valid, 1'b0);
    chk("stall_wait", MEMEX_stall, 1'b1);
    if (no_resp) begin
      repeat (TO - 1) begin
        @(posedge clk); #1;
        chk("no_early_wb", {MEMWB_ready, MEMEX_stall}, 2'b01);
      end
      exp_q.push_back({1'b1, {REG_W{1'b0}}, 64'd0});
      @(posedge clk); #1;
      chk("timeout_wb", {MEMWB_ready, mem_err, MEMEX_stall}, 3'b110);
    end else begin
      repeat (resp_dly - 1) begin
        @(posedge clk); #1;
        chk("stall_resp", {MEMWB_ready, MEMEX_stall}, 2'b01);
      end
      mif.dmem_resp_valid = 1'b1;
      mif.dmem_rdata = rdata;
      exp_q.push_back({1'b0, ld ? rd : {REG_W{1'b0}}, ld ? model_load(rdata, a, sz, uns) : 64'd0});
      @(posedge clk); #1;
      mif.dmem_resp_valid = 1'b0;
      chk("resp_wb", {MEMWB_ready, MEMEX_stall}, 2'b10);
    end
  endtask

  initial begin
    reset = 1'b0;
    EXMEM_ready = 0; exmm_aluresult = '0; EXMEM_rs2 = '0; dest_reg = '0;
    mem_active = 0; load = 0; EXMEM_size = '0; EXMEM_unsigned = 0;
    mif.dmem_req_ready = 0; mif.dmem_resp_valid = 0; mif.dmem_rdata = '0;
    #3;
    chk("reset_outs", {MEMEX_stall, MEMWB_ready, MEMWB_rd, MEMWB_val, mem_err, mif.dmem_req_valid}, '0);
    chk("reset_state", dbg_state, 2'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // ALU passthrough
    run_op(6'd5, 64'h1234, 64'd0, 0, 0, 2'd0, 0, 0, 0, 64'd0, 0);
    chk("pass_rd", MEMWB_rd, 6'd5);
    chk("pass_val", MEMWB_val, 64'h1234);
    chk("pass_fwd_rd", MEMEX_rd, 6'd5);

    // signed / unsigned byte load
    run_op(6'd7, 64'h1003, 64'd0, 1, 1, 2'd0, 0, 2, 3, 64'h0000_0000_8000_0000, 0);
    chk("sb_val", MEMWB_val, 64'hFFFF_FFFF_FFFF_FF80);
    chk("sb_addr", mif.dmem_addr, 64'h1000);
    run_op(6'd7, 64'h1003, 64'd0, 1, 1, 2'd0, 1, 2, 3, 64'h0000_0000_8000_0000, 0);
    chk("ub_val", MEMWB_val, 64'h80);

    // word store
    run_op(6'd9, 64'h2004, 64'hAABB_CCDD_1122_3344, 1, 0, 2'd2, 0, 0, 1, 64'd0, 0);
    chk("sw_wstrb", mif.dmem_wstrb, 8'hF0);
    chk("sw_wdata_hi", mif.dmem_wdata[63:32], 32'h1122_3344);
    chk("sw_we", mif.dmem_we, 1'b1);
    chk("sw_rd", MEMWB_rd, 6'd0);

    // misaligned half load
    run_op(6'd4, 64'h3001, 64'd0, 1, 1, 2'd1, 0, 0, 0, 64'd0, 0);
    chk("mis_rd", {mem_err, MEMWB_rd}, {1'b1, 6'd0});

    // timeout, then a stray response in IDLE
    run_op(6'd3, 64'h4000, 64'd0, 1, 1, 2'd3, 0, 1, 0, 64'd0, 1);
    mif.dmem_resp_valid = 1'b1; mif.dmem_rdata = 64'hDEAD;
    @(posedge clk); #1;
    mif.dmem_resp_valid = 1'b0;
    chk("late_resp_ignored", {MEMWB_ready, MEMEX_stall, dbg_state}, 4'b0000);

    // additional lanes and sizes
    run_op(6'd10, 64'h5006, 64'd0, 1, 1, 2'd1, 1, 1, 2, 64'hBEEF_0000_0000_0000, 0);
    chk("lhu_val", MEMWB_val, 64'hBEEF);
    run_op(6'd11, 64'h6004, 64'd0, 1, 1, 2'd2, 0, 0, 3, 64'h8765_4321_0000_0000, 0);
    chk("lw_val", MEMWB_val, 64'hFFFF_FFFF_8765_4321);
    run_op(6'd12, 64'h7005, 64'h1234_5678_9ABC_DEAB, 1, 0, 2'd0, 0, 1, 1, 64'd0, 0);
    chk("sb_wstrb", mif.dmem_wstrb, 8'h20);
    run_op(6'd13, 64'h8000, 64'h0102_0304_0506_0708, 1, 0, 2'd3, 0, 0, 2, 64'd0, 0);
    run_op(6'd14, 64'h9000, 64'd0, 1, 1, 2'd3, 0, 0, 1, 64'hFEDC_BA98_7654_3210, 0);
    chk("ld_val", MEMWB_val, 64'hFEDC_BA98_7654_3210);

    // reset while waiting for a response
    drive_op(6'd9, 64'hA000, 64'd0, 1, 1, 2'd3, 0);
    @(posedge clk); #1;
    EXMEM_ready = 1'b0; mem_active = 1'b0; mif.dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    mif.dmem_req_ready = 1'b0;
    chk("in_wait", dbg_state, 2'd2);
    reset = 1'b0;
    #1;
    chk("rst_outs", {MEMEX_stall, MEMWB_ready, MEMWB_rd, MEMWB_val, mem_err}, '0);
    chk("rst_bus", {mif.dmem_req_valid, mif.dmem_addr, mif.dmem_we, mif.dmem_wstrb}, '0);
    chk("rst_state", dbg_state, 2'd0);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    run_op(6'd3, 64'hCAFE, 64'd0, 0, 0, 2'd0, 0, 0, 0, 64'd0, 0);
    chk("post_rst_val", MEMWB_val, 64'hCAFE);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no completion required finish");
    $fatal(1);
  end
endmodule
